// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-class CPU core.
// Instructions are fetched over a request/valid handshake, so program memory
// may insert any number of wait cycles. The core has IN_CH input channels,
// an OUT register driving the LEDs, and a terminal HLT instruction.
module td4x_core #(
    parameter int DATA_W = 4,
    parameter int IN_CH  = 1,
    parameter int INSN_W = DATA_W + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [IN_CH*DATA_W-1:0] in_data,
    output logic [DATA_W-1:0]       out_data,
    output logic                    mem_req,
    output logic [DATA_W-1:0]       mem_addr,
    input  logic [INSN_W-1:0]       mem_rdata,
    input  logic                    mem_valid,
    output logic                    carry,
    output logic                    halted
);
    // Width of the channel index taken from imm (at least one bit so the
    // slice below stays legal when there is a single channel).
    localparam int CH_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_JMP    = 4'b1111;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1000;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   a_r, a_s, b_r, b_s, out_r, out_s, ip_r, ip_s;
    logic                carry_r, carry_s, req_r, req_s, halted_r, halted_s;
    logic [INSN_W-1:0]   insn_r, insn_s;

    logic [3:0]          opcode_s;
    logic [DATA_W-1:0]   imm_s, ip_inc_s, in_val_s;
    logic [DATA_W:0]     sum_a_s, sum_b_s;
    logic [31:0]         ch_idx_s;

    assign opcode_s = insn_r[INSN_W-1 -: 4];
    assign imm_s    = insn_r[DATA_W-1:0];
    assign ip_inc_s = ip_r + {{(DATA_W-1){1'b0}}, 1'b1};
    assign sum_a_s  = {1'b0, a_r} + {1'b0, imm_s};
    assign sum_b_s  = {1'b0, b_r} + {1'b0, imm_s};

    assign out_data = out_r;
    assign mem_req  = req_r;
    assign mem_addr = ip_r;
    assign carry    = carry_r;
    assign halted   = halted_r;

    // Input channel mux: low CH_W bits of imm, folded into range with mod IN_CH.
    always_comb begin
        ch_idx_s = 32'(imm_s[CH_W-1:0]) % 32'(IN_CH);
        in_val_s = {DATA_W{1'b0}};
        for (int k = 0; k < IN_CH; k++) begin
            if (ch_idx_s == 32'(k)) begin
                in_val_s = in_data[k*DATA_W +: DATA_W];
            end else begin
                in_val_s = in_val_s;
            end
        end
    end

    // Next-state and next-register logic for the FETCH/WAIT/EXEC/HALT sequencer.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        out_s    = out_r;
        ip_s     = ip_r;
        carry_s  = carry_r;
        insn_s   = insn_r;
        req_s    = req_r;
        halted_s = halted_r;
        case (state_r)
            ST_FETCH: begin
                if (run) begin
                    req_s   = 1'b1;
                    state_s = ST_WAIT;
                end else begin
                    req_s   = 1'b0;
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    insn_s  = mem_rdata;
                    req_s   = 1'b0;
                    state_s = ST_EXEC;
                end else begin
                    req_s   = 1'b1;
                    state_s = ST_WAIT;
                end
            end
            ST_EXEC: begin
                state_s = ST_FETCH;
                ip_s    = ip_inc_s;
                carry_s = 1'b0;
                case (opcode_s)
                    OP_ADD_A:  {carry_s, a_s} = sum_a_s;
                    OP_ADD_B:  {carry_s, b_s} = sum_b_s;
                    OP_MOV_AI: a_s = imm_s;
                    OP_MOV_BI: b_s = imm_s;
                    OP_MOV_AB: a_s = b_r;
                    OP_MOV_BA: b_s = a_r;
                    OP_IN_A:   a_s = in_val_s;
                    OP_IN_B:   b_s = in_val_s;
                    OP_OUT_I:  out_s = imm_s;
                    OP_OUT_B:  out_s = b_r;
                    OP_JMP:    ip_s = imm_s;
                    OP_JNC: begin
                        // Condition uses the carry left by the previous instruction.
                        if (!carry_r) begin
                            ip_s = imm_s;
                        end else begin
                            ip_s = ip_inc_s;
                        end
                    end
                    OP_HLT: begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                    end
                    default: begin
                        ip_s = ip_inc_s;
                    end
                endcase
            end
            ST_HALT: begin
                state_s  = ST_HALT;
                req_s    = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s  = ST_FETCH;
                req_s    = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; rst clears everything and wins over all else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_FETCH;
            a_r      <= {DATA_W{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            out_r    <= {DATA_W{1'b0}};
            ip_r     <= {DATA_W{1'b0}};
            carry_r  <= 1'b0;
            insn_r   <= {INSN_W{1'b0}};
            req_r    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            out_r    <= out_s;
            ip_r     <= ip_s;
            carry_r  <= carry_s;
            insn_r   <= insn_s;
            req_r    <= req_s;
            halted_r <= halted_s;
        end
    end

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard testbench for td4x_core: a 4-bit/4-channel core and an 8-bit
// single-channel core share one program memory model; sel picks the active one.
module tb_td4x_core;
    typedef struct { int addr; int gap; int cy; } fexp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        run      = 1'b0;
    logic        sel      = 1'b0;
    logic        stray    = 1'b0;
    int          wait_cyc = 0;
    logic [15:0] in4      = 16'h4321;
    logic [7:0]  in8      = 8'h5C;
    logic [11:0] prog [256];
    logic [11:0] rdata    = 12'h800;
    logic        valid    = 1'b0;

    logic        run4, run8, valid4, valid8, req4, req8, cy4, cy8, h4, h8;
    logic [3:0]  out4, addr4;
    logic [7:0]  out8, addr8, rdata4;
    logic        m_req, m_cy, m_halt;
    logic [7:0]  m_addr, m_out;

    fexp_t fq[$];
    int    oq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    assign run4   = run & ~sel;
    assign run8   = run & sel;
    assign valid4 = valid & ~sel;
    assign valid8 = valid & sel;
    assign rdata4 = rdata[7:0];
    assign m_req  = sel ? req8  : req4;
    assign m_cy   = sel ? cy8   : cy4;
    assign m_halt = sel ? h8    : h4;
    assign m_addr = sel ? addr8 : {4'h0, addr4};
    assign m_out  = sel ? out8  : {4'h0, out4};

    td4x_core #(.DATA_W(4), .IN_CH(4)) u_dut4 (
        .clk(clk), .rst(rst), .run(run4), .in_data(in4), .out_data(out4),
        .mem_req(req4), .mem_addr(addr4), .mem_rdata(rdata4), .mem_valid(valid4),
        .carry(cy4), .halted(h4)
    );

    td4x_core #(.DATA_W(8), .IN_CH(1)) u_dut8 (
        .clk(clk), .rst(rst), .run(run8), .in_data(in8), .out_data(out8),
        .mem_req(req8), .mem_addr(addr8), .mem_rdata(rdata), .mem_valid(valid8),
        .carry(cy8), .halted(h8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_f(input int a, input int g, input int c);
        fq.push_back('{addr: a, gap: g, cy: c});
    endtask

    task automatic clear_prog(input logic [11:0] fill);
        for (int i = 0; i < 256; i++) prog[i] = fill;
    endtask

    task automatic do_reset(input logic new_sel);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        sel = new_sel;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_addr(input int a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (m_req && m_addr == 8'(a)) found = 1'b1;
        end
        chk("wait_fetch_seen", 32'(found), 32'd1);
    endtask

    task automatic finish_halt();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (m_halt) found = 1'b1;
        end
        chk("halt_reached", 32'(found), 32'd1);
        repeat (4) @(negedge clk);
        chk("halt_req_low_end", 32'(m_req), 32'd0);
        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        chk("out_queue_drained", 32'(oq.size()), 32'd0);
        fq.delete();
        oq.delete();
    endtask

    // Program memory: answers a request after wait_cyc idle cycles; may also
    // emit stray valid strobes (carrying a HLT word) while no request is open.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (m_req) begin
                wcnt++;
                if (wcnt > wait_cyc) begin
                    valid = 1'b1;
                    rdata = prog[m_addr];
                end else begin
                    valid = 1'b0;
                    rdata = sel ? 12'h800 : 12'h080;
                end
            end else begin
                wcnt  = 0;
                valid = stray;
                rdata = sel ? 12'h800 : 12'h080;
            end
        end
    end

    int          cyc        = 0;
    int          last_fetch = -1;
    logic        prev_req   = 1'b0;
    logic [7:0]  prev_out   = 8'h00;
    logic [7:0]  hold_addr  = 8'h00;

    // Monitor: pops fetch and OUT expectations whenever the core presents them.
    initial begin
        fexp_t f;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_req   = 1'b0;
                prev_out   = m_out;
                last_fetch = -1;
            end else begin
                if (m_req && !prev_req) begin
                    if (fq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_fetch: got addr 0x%0h, want no fetch", m_addr);
                    end else begin
                        f = fq.pop_front();
                        chk("fetch_addr", 32'(m_addr), 32'(f.addr));
                        if (f.gap > 0) chk("fetch_gap", 32'(cyc - last_fetch), 32'(f.gap));
                        if (f.cy >= 0) chk("carry", 32'(m_cy), 32'(f.cy));
                    end
                    hold_addr  = m_addr;
                    last_fetch = cyc;
                end else if (m_req) begin
                    chk("addr_stable", 32'(m_addr), 32'(hold_addr));
                end
                if (m_out != prev_out) begin
                    if (oq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out: got 0x%0h, want 0x%0h", m_out, prev_out);
                    end else begin
                        chk("out_data", 32'(m_out), 32'(oq.pop_front()));
                    end
                end
                if (m_halt) chk("halt_req_low", 32'(m_req), 32'd0);
                prev_req = m_req;
                prev_out = m_out;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        // Reset and idle with run low.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_req", 32'(m_req), 32'd0);
            chk("idle_out", 32'(m_out), 32'd0);
            chk("idle_halted", 32'(m_halt), 32'd0);
            chk("idle_carry", 32'(m_cy), 32'd0);
        end

        // Add with carry, JNC not taken, OUT imm, expose A through B, HLT.
        clear_prog(12'h080);
        prog[0] = 12'h03E; prog[1] = 12'h003; prog[2] = 12'h0E0; prog[3] = 12'h0B5;
        prog[4] = 12'h040; prog[5] = 12'h090; prog[6] = 12'h080;
        push_f(0, -1, -1); push_f(1, 3, 0); push_f(2, 3, 1); push_f(3, 3, 0);
        push_f(4, 3, 0);  push_f(5, 3, 0); push_f(6, 3, 0);
        oq.push_back(5); oq.push_back(1);
        run = 1'b1;
        finish_halt();

        // Wait-stated fetch with stray valid strobes outside WAIT.
        do_reset(1'b0);
        wait_cyc = 4;
        stray    = 1'b1;
        clear_prog(12'h080);
        prog[0] = 12'h079; prog[1] = 12'h090; prog[2] = 12'h080;
        push_f(0, -1, -1); push_f(1, 7, 0); push_f(2, 7, 0);
        oq.push_back(9);
        run = 1'b1;
        finish_halt();
        stray    = 1'b0;
        wait_cyc = 0;

        // Multi-channel input: channels 1,2,3,4; imm 2 and 6 both pick channel 2.
        do_reset(1'b0);
        clear_prog(12'h080);
        prog[0] = 12'h022; prog[1] = 12'h040; prog[2] = 12'h090; prog[3] = 12'h0B0;
        prog[4] = 12'h026; prog[5] = 12'h040; prog[6] = 12'h090; prog[7] = 12'h065;
        prog[8] = 12'h090; prog[9] = 12'h080;
        push_f(0, -1, -1);
        for (int k = 1; k <= 9; k++) push_f(k, 3, 0);
        oq.push_back(3); oq.push_back(0); oq.push_back(3); oq.push_back(2);
        run = 1'b1;
        finish_halt();

        // IP loop: NOPs at 0..14, JMP 0 at 15; entry 0 becomes HLT on the revisit.
        do_reset(1'b0);
        clear_prog(12'h080);
        for (int k = 0; k < 15; k++) prog[k] = (k % 3 == 0) ? 12'h0C0 : ((k % 3 == 1) ? 12'h0A3 : 12'h0D7);
        prog[15] = 12'h0F0;
        push_f(0, -1, -1);
        for (int k = 1; k <= 15; k++) push_f(k, 3, 0);
        push_f(0, 3, 0);
        run = 1'b1;
        wait_addr(1);
        prog[0] = 12'h080;
        finish_halt();

        // NOP at address 15 falls through to address 0.
        do_reset(1'b0);
        clear_prog(12'h080);
        prog[0] = 12'h0FF; prog[15] = 12'h0C0;
        push_f(0, -1, -1); push_f(15, 3, 0); push_f(0, 3, 0);
        run = 1'b1;
        wait_addr(15);
        prog[0] = 12'h080;
        finish_halt();

        // Reset while in WAIT, then late valid strobes; restart must begin at 0.
        do_reset(1'b0);
        wait_cyc = 4;
        clear_prog(12'h080);
        prog[0] = 12'h075; prog[1] = 12'h090; prog[2] = 12'h039; prog[3] = 12'h009;
        prog[4] = 12'h0C0;
        push_f(0, -1, -1); push_f(1, 7, 0); push_f(2, 7, 0); push_f(3, 7, 0); push_f(4, 7, 1);
        oq.push_back(5);
        run = 1'b1;
        wait_addr(4);
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;
        chk("req_after_rst", 32'(m_req), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("req_late_valid", 32'(m_req), 32'd0);
        end
        chk("rst_out", 32'(m_out), 32'd0);
        chk("rst_carry", 32'(m_cy), 32'd0);
        chk("rst_queue_empty", 32'(fq.size()), 32'd0);
        stray    = 1'b0;
        wait_cyc = 0;
        clear_prog(12'h080);
        prog[0] = 12'h001; prog[1] = 12'h040; prog[2] = 12'h090; prog[3] = 12'h0E5;
        prog[5] = 12'h080;
        push_f(0, -1, -1); push_f(1, 3, 0); push_f(2, 3, 0); push_f(3, 3, 0); push_f(5, 3, 0);
        oq.push_back(1);
        run = 1'b1;
        finish_halt();

        // Width scaling: 8-bit core, 0x01 + 0xFF wraps with carry, 8-bit addresses.
        do_reset(1'b1);
        clear_prog(12'h800);
        prog[0] = 12'h301; prog[1] = 12'h0FF; prog[2] = 12'hBAA; prog[3] = 12'h400;
        prog[4] = 12'h900; prog[5] = 12'h2B7; prog[6] = 12'h400; prog[7] = 12'h900;
        prog[8] = 12'hFFE; prog[254] = 12'hC00; prog[255] = 12'h800;
        push_f(0, -1, -1); push_f(1, 3, 0); push_f(2, 3, 1);
        for (int k = 3; k <= 8; k++) push_f(k, 3, 0);
        push_f(254, 3, 0); push_f(255, 3, 0);
        oq.push_back(8'hAA); oq.push_back(8'h00); oq.push_back(8'h5C);
        run = 1'b1;
        finish_halt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
